// File: rtl/sys_ctrl_param.sv
// Command-frame controller between the UART RX/TX pair and the register file/ALU.
// Parses write/read/ALU frames and streams responses back through a held valid/busy handshake.
module sys_ctrl_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int FUN_W     = 4,
    parameter int RES_BYTES = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_W-1:0]           RX_P_DATA,
    input  logic                        RX_D_VLD,
    input  logic [DATA_W*RES_BYTES-1:0] ALU_OUT,
    input  logic                        OUT_Valid,
    input  logic [DATA_W-1:0]           RdData,
    input  logic                        RdData_Valid,
    input  logic                        TX_Busy,
    output logic                        EN,
    output logic [FUN_W-1:0]            ALU_FUN,
    output logic                        CLK_EN,
    output logic [ADDR_W-1:0]           Address,
    output logic                        WrEn,
    output logic                        RdEn,
    output logic [DATA_W-1:0]           WrData,
    output logic [DATA_W-1:0]           TX_P_DATA,
    output logic                        TX_D_VLD
);

    localparam int RES_W = DATA_W * RES_BYTES;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = $clog2(RES_BYTES + 1);

    localparam logic [DATA_W-1:0] CMD_WR     = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD     = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU_OP = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_ALU    = DATA_W'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
        S_OP_A, S_OP_B, S_FUN, S_ALU_WAIT, S_TX
    } state_t;

    state_t              r_state,  w_state;
    logic [ADDR_W-1:0]   r_addr,   w_addr;
    logic [FUN_W-1:0]    r_fun,    w_fun;
    logic [DATA_W-1:0]   r_wrData, w_wrData;
    logic                r_wrEn,   w_wrEn;
    logic                r_rdEn,   w_rdEn;
    logic                r_en,     w_en;
    logic                r_txVld,  w_txVld;
    logic [DATA_W-1:0]   r_txData, w_txData;
    logic [RES_W-1:0]    r_txBuf,  w_txBuf;
    logic [CNT_W-1:0]    r_txLeft, w_txLeft;
    logic [TMR_W-1:0]    r_timer,  w_timer;
    logic                w_timeout;

    always_comb begin
        w_state   = r_state;
        w_addr    = r_addr;
        w_fun     = r_fun;
        w_wrData  = r_wrData;
        w_wrEn    = 1'b0;
        w_rdEn    = 1'b0;
        w_en      = 1'b0;
        w_txVld   = r_txVld;
        w_txData  = r_txData;
        w_txBuf   = r_txBuf;
        w_txLeft  = r_txLeft;
        w_timeout = (r_timer == TMR_W'(TIMEOUT));

        // Timeout takes priority over any byte arriving in the same cycle
        if (r_state != S_IDLE && r_state != S_TX && w_timeout) begin
            w_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_WR:     w_state = S_WR_ADDR;
                            CMD_RD:     w_state = S_RD_ADDR;
                            CMD_ALU_OP: w_state = S_OP_A;
                            CMD_ALU:    w_state = S_FUN;
                            default:    w_state = S_IDLE;
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        w_addr  = RX_P_DATA[ADDR_W-1:0];
                        w_state = S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        w_wrData = RX_P_DATA;
                        w_wrEn   = 1'b1;
                        w_state  = S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        w_addr  = RX_P_DATA[ADDR_W-1:0];
                        w_rdEn  = 1'b1;
                        w_state = S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (RdData_Valid) begin
                        w_txBuf  = RES_W'(RdData);
                        w_txLeft = CNT_W'(1);
                        w_state  = S_TX;
                    end
                end
                S_OP_A: begin
                    if (RX_D_VLD) begin
                        w_addr   = '0;
                        w_wrData = RX_P_DATA;
                        w_wrEn   = 1'b1;
                        w_state  = S_OP_B;
                    end
                end
                S_OP_B: begin
                    if (RX_D_VLD) begin
                        w_addr   = ADDR_W'(1);
                        w_wrData = RX_P_DATA;
                        w_wrEn   = 1'b1;
                        w_state  = S_FUN;
                    end
                end
                S_FUN: begin
                    if (RX_D_VLD) begin
                        w_fun   = RX_P_DATA[FUN_W-1:0];
                        w_en    = 1'b1;
                        w_state = S_ALU_WAIT;
                    end
                end
                S_ALU_WAIT: begin
                    if (OUT_Valid) begin
                        w_txBuf  = ALU_OUT;
                        w_txLeft = CNT_W'(RES_BYTES);
                        w_state  = S_TX;
                    end
                end
                S_TX: begin
                    // A byte counts as taken once busy is seen while it is presented
                    if (r_txVld) begin
                        if (TX_Busy) begin
                            w_txVld  = 1'b0;
                            w_txBuf  = r_txBuf >> DATA_W;
                            w_txLeft = r_txLeft - CNT_W'(1);
                            if (r_txLeft == CNT_W'(1)) begin
                                w_state = S_IDLE;
                            end
                        end
                    end else if (!TX_Busy) begin
                        w_txVld  = 1'b1;
                        w_txData = r_txBuf[DATA_W-1:0];
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end

        if (w_state != r_state || r_state == S_IDLE || r_state == S_TX) begin
            w_timer = '0;
        end else begin
            w_timer = r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_fun    <= '0;
            r_wrData <= '0;
            r_wrEn   <= 1'b0;
            r_rdEn   <= 1'b0;
            r_en     <= 1'b0;
            r_txVld  <= 1'b0;
            r_txData <= '0;
            r_txBuf  <= '0;
            r_txLeft <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state;
            r_addr   <= w_addr;
            r_fun    <= w_fun;
            r_wrData <= w_wrData;
            r_wrEn   <= w_wrEn;
            r_rdEn   <= w_rdEn;
            r_en     <= w_en;
            r_txVld  <= w_txVld;
            r_txData <= w_txData;
            r_txBuf  <= w_txBuf;
            r_txLeft <= w_txLeft;
            r_timer  <= w_timer;
        end
    end

    assign EN        = r_en;
    assign ALU_FUN   = r_fun;
    assign CLK_EN    = (r_state == S_ALU_WAIT);
    assign Address   = r_addr;
    assign WrEn      = r_wrEn;
    assign RdEn      = r_rdEn;
    assign WrData    = r_wrData;
    assign TX_P_DATA = r_txData;
    assign TX_D_VLD  = r_txVld;

endmodule

// File: tb/tb_sys_ctrl_param.sv
// Directed bench for sys_ctrl_param: vector table for frame parsing, hand sequences for
// TX handshake, backpressure, timeout and reset during transmission.
module tb_sys_ctrl_param;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int FUN_W     = 4;
    localparam int RES_BYTES = 2;
    localparam int TIMEOUT   = 1023;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic        TX_Busy = 1'b0;
    logic        EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_EN;
    logic [3:0]  Address;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  WrData;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    int checks = 0;
    int errors = 0;

    sys_ctrl_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W),
        .RES_BYTES(RES_BYTES), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .TX_Busy(TX_Busy),
        .EN(EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rxVld;
        logic [7:0] rxByte;
        logic       expWrEn;
        logic       expRdEn;
        logic       expEn;
        logic       expClkEn;
        logic [3:0] expAddr;
        logic [7:0] expWrData;
        logic [3:0] expFun;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [28:0] allOutputs();
        return {EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD};
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One RX byte per call; consecutive calls give back-to-back strobes
    task automatic applyStimulus(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic pulseAluResult(input logic [15:0] res);
        ALU_OUT   = res;
        OUT_Valid = 1'b1;
        tick();
        OUT_Valid = 1'b0;
    endtask

    // Transmitter model: busy for preBusy cycles, then idle until a byte is presented,
    // keeps it waiting holdCycles, then accepts by raising busy.
    task automatic txReceive(input logic [7:0] expByte, input int preBusy, input int holdCycles);
        int vldSeen = 0;
        int unstable = 0;
        logic found = 1'b0;
        logic [7:0] firstData;
        TX_Busy = 1'b1;
        repeat (preBusy) begin
            tick();
            if (TX_D_VLD) vldSeen++;
        end
        checkOutput("tx quiet while busy", vldSeen, 0);
        TX_Busy = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (TX_D_VLD) found = 1'b1;
        end
        checkOutput("tx presented", {31'b0, found}, 1);
        firstData = TX_P_DATA;
        checkOutput("tx byte", {24'b0, TX_P_DATA}, {24'b0, expByte});
        repeat (holdCycles) begin
            tick();
            if (!TX_D_VLD || TX_P_DATA !== firstData) unstable++;
        end
        checkOutput("tx held stable", unstable, 0);
        TX_Busy = 1'b1;
        tick();
        checkOutput("tx vld drops after busy", {31'b0, TX_D_VLD}, 0);
    endtask

    task automatic noExtraTx();
        int cnt = 0;
        TX_Busy = 1'b0;
        repeat (20) begin
            tick();
            if (TX_D_VLD) cnt++;
        end
        checkOutput("no extra tx byte", cnt, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0};
        vecs[1]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0};
        vecs[2]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0};
        vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0};
        vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0};
        vecs[6]  = '{1'b1, 8'hFA, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0};
        vecs[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 8'hFF, 4'h0};
        vecs[8]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 4'h0};
        vecs[9]  = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h07, 4'h0};
        vecs[10] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'h03, 4'h0};
        vecs[11] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 4'h2};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 4'h0};

        #1 RST = 1'b1;
        #1 checkOutput("reset outputs", {3'b0, allOutputs()}, 0);
        repeat (2) tick();
        RST = 1'b0;
        tick();

        // Write, unknown-command and ALU-with-operands frames, back-to-back bytes
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rxVld) applyStimulus(vecs[i].rxByte);
            else tick();
            checkOutput($sformatf("vec%0d pulses", i),
                        {27'b0, WrEn, RdEn, EN, CLK_EN, TX_D_VLD},
                        {27'b0, vecs[i].expWrEn, vecs[i].expRdEn, vecs[i].expEn, vecs[i].expClkEn, 1'b0});
            if (vecs[i].expWrEn || vecs[i].expRdEn)
                checkOutput($sformatf("vec%0d address", i), {28'b0, Address}, {28'b0, vecs[i].expAddr});
            if (vecs[i].expWrEn)
                checkOutput($sformatf("vec%0d wrdata", i), {24'b0, WrData}, {24'b0, vecs[i].expWrData});
            if (vecs[i].expEn)
                checkOutput($sformatf("vec%0d alu_fun", i), {28'b0, ALU_FUN}, {28'b0, vecs[i].expFun});
        end

        tick();
        checkOutput("clk_en held waiting", {31'b0, CLK_EN}, 1);
        pulseAluResult(16'h0015);
        checkOutput("clk_en after out_valid", {31'b0, CLK_EN}, 0);
        checkOutput("no tx in capture cycle", {31'b0, TX_D_VLD}, 0);
        txReceive(8'h15, 2, 3);
        txReceive(8'h00, 2, 3);
        noExtraTx();

        // Read frame; a stray OUT_Valid while waiting must not start a response
        applyStimulus(8'hBB);
        applyStimulus(8'h05);
        checkOutput("read pulse", {26'b0, RdEn, WrEn, Address}, {26'b0, 1'b1, 1'b0, 4'h5});
        tick();
        checkOutput("read pulse single", {31'b0, RdEn}, 0);
        pulseAluResult(16'hFFFF);
        repeat (3) tick();
        checkOutput("out_valid ignored in rd_wait", {31'b0, TX_D_VLD}, 0);
        RdData = 8'h3C;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        txReceive(8'h3C, 2, 3);
        noExtraTx();

        // Backpressure on a no-operand ALU frame
        applyStimulus(8'hDD);
        applyStimulus(8'h05);
        checkOutput("dd en pulse", {26'b0, EN, CLK_EN, ALU_FUN}, {26'b0, 1'b1, 1'b1, 4'h5});
        pulseAluResult(16'hA55A);
        txReceive(8'h5A, 50, 5);
        txReceive(8'hA5, 50, 5);
        noExtraTx();

        // Data byte lands exactly on the timeout expiry and must be dropped
        applyStimulus(8'hAA);
        applyStimulus(8'h05);
        repeat (TIMEOUT) tick();
        applyStimulus(8'h3C);
        checkOutput("no write after timeout", {31'b0, WrEn}, 0);
        tick();
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h77);
        checkOutput("write after timeout recovery", {19'b0, WrEn, Address, WrData}, {19'b0, 1'b1, 4'h1, 8'h77});

        // Asynchronous reset while a byte is presented
        applyStimulus(8'hDD);
        applyStimulus(8'h03);
        TX_Busy = 1'b0;
        pulseAluResult(16'h1234);
        tick();
        checkOutput("tx presented before reset", {24'b0, TX_P_DATA}, {24'b0, 8'h34});
        #2 RST = 1'b1;
        #1 checkOutput("outputs cleared by reset", {3'b0, allOutputs()}, 0);
        tick();
        RST = 1'b0;
        tick();
        applyStimulus(8'hDD);
        checkOutput("dd alone no en", {31'b0, EN}, 0);
        applyStimulus(8'h00);
        checkOutput("post-reset alu start", {26'b0, EN, CLK_EN, ALU_FUN}, {26'b0, 1'b1, 1'b1, 4'h0});
        pulseAluResult(16'h0042);
        txReceive(8'h42, 2, 2);
        txReceive(8'h00, 2, 2);
        noExtraTx();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_param.md
# sys_ctrl_param

Parametrised system controller between the UART RX/TX pair and the register file/ALU. It parses byte-serial command frames from the UART receiver and issues register-file writes and reads plus ALU operations. It returns read data and multi-byte ALU results to the UART transmitter through a held valid/busy handshake. Compared with the previous controller it adds generic widths, multi-byte ALU results, an inter-byte timeout and unknown-command rejection.

## Interface
- DATA_W, 8, width of UART bytes and register data
- ADDR_W, 4, register-file address width
- FUN_W, 4, ALU function code width
- RES_BYTES, 2, ALU result width in bytes; ALU_OUT is DATA_W*RES_BYTES
- TIMEOUT, 1023, idle cycles allowed between frame bytes or while waiting for a response
- CLK  in  1  single clock for the block
- RST  in  1  asynchronous reset, active-high
- RX_P_DATA  in  DATA_W  received byte
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid
- ALU_OUT  in  DATA_W*RES_BYTES  ALU result
- OUT_Valid  in  1  ALU_OUT is valid
- RdData  in  DATA_W  register-file read data
- RdData_Valid  in  1  RdData is valid
- TX_Busy  in  1  transmitter busy
- EN  out  1  one-cycle ALU start pulse
- ALU_FUN  out  FUN_W  ALU function code
- CLK_EN  out  1  ALU clock-gate enable
- Address  out  ADDR_W  register-file address
- WrEn / RdEn  out  1  one-cycle register-file write/read pulses
- WrData  out  DATA_W  register-file write data
- TX_P_DATA  out  DATA_W  byte to transmit
- TX_D_VLD  out  1  TX_P_DATA is valid; held until accepted

## Operation
- Command byte codes: 0xAA = write (addr, data); 0xBB = read (addr); 0xCC = ALU with operands (A, B, fun); 0xDD = ALU without operands (fun).
- Only the low ADDR_W and FUN_W bits of address and function bytes are used.
- Any other command byte is discarded and the FSM stays in IDLE.
- FSM states:
  - IDLE; WR_ADDR -> WR_DATA; RD_ADDR -> RD_WAIT; OP_A -> OP_B -> FUN; FUN -> ALU_WAIT; TX.
  - 0xDD goes directly IDLE -> FUN.
- Write frame: the data byte produces WrEn=1 for one cycle with Address equal to the latched address and WrData equal to the byte; the FSM then returns to IDLE.
- Read frame: the address byte produces RdEn=1 for one cycle; the FSM waits in RD_WAIT for RdData_Valid, captures RdData as a single response byte, then enters TX.
- ALU frame:
  - The OP_A byte writes register address 0 and the OP_B byte writes address 1, each via a WrEn pulse.
  - The fun byte sets ALU_FUN and pulses EN for one cycle.
  - CLK_EN is high from the cycle after the fun byte until OUT_Valid is sampled.
  - ALU_OUT is captured on OUT_Valid; TX then sends RES_BYTES bytes, least-significant byte first.
- TX handshake:
  - A byte is presented (TX_D_VLD=1) only when TX_Busy is sampled 0.
  - TX_D_VLD and TX_P_DATA are held until TX_Busy is sampled 1, then TX_D_VLD drops.
  - The next byte is presented only after TX_Busy is sampled 0 again.
  - After the last byte is accepted, the FSM returns to IDLE.
- RX bytes arriving in RD_WAIT, ALU_WAIT or TX are dropped.
- Timeout:
  - A counter runs in every state except IDLE and TX. It clears on each accepted RX_D_VLD and on state entry.
  - When the counter reaches TIMEOUT, the FSM returns to IDLE and issues no pending WrEn, RdEn or EN; CLK_EN drops.
- Address and ALU_FUN hold their last values in IDLE.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset is asynchronous and may occur mid-frame or mid-TX.
- When reset asserts during TX, TX_D_VLD drops immediately.
- WrEn, RdEn and EN are asserted in the cycle after the triggering RX_D_VLD.
- The first TX_D_VLD is asserted no earlier than the cycle after the RdData_Valid or OUT_Valid capture.
- Back-to-back RX_D_VLD on consecutive cycles is accepted; each byte advances the FSM by one state.
- If RX_D_VLD coincides with the timeout expiry, the timeout wins and the byte is dropped.
- RdData_Valid and OUT_Valid are ignored outside RD_WAIT and ALU_WAIT respectively.

## Test plan
- Write: frame AA,05,3C -> a single WrEn pulse with Address=5 and WrData=0x3C; no TX_D_VLD.
- Read: frame BB,05, then RdData=0x3C with RdData_Valid -> one RdEn pulse with Address=5; TX sends 0x3C once under the hold-until-busy rule.
- ALU with operands:
  - Stimulus: frame CC,07,03,02; ALU_OUT=0x0015 with OUT_Valid.
  - Register writes: addr0=07 and addr1=03 via WrEn pulses.
  - ALU control: EN pulse with ALU_FUN=2; CLK_EN high until OUT_Valid.
  - Response: TX sends 15 then 00.
- Backpressure: hold TX_Busy=1 for 50 cycles before accepting each byte -> TX_D_VLD and data remain stable; exactly RES_BYTES bytes are sent with no duplicates.
- Timeout and unknown command:
  - Frame AA,05, then silence for TIMEOUT cycles, then 0x3C -> no WrEn; FSM back in IDLE; the late byte is treated as an unknown command.
  - Frame 0x11 -> ignored.
- Reset in TX: assert RST while TX_D_VLD=1 -> all outputs 0 immediately; a subsequent DD,00 frame operates normally.
